// File: rtl/seq_div24.sv
// Sequential restoring divider: 48-bit dividend / 24-bit divisor, one quotient bit per clock.
// Shares the start/ready handshake of the 24x24 shift-add multiplier.
module seq_div24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        startDiv,
  input  logic [47:0] N,
  input  logic [23:0] D,
  output logic [23:0] Q,
  output logic [23:0] R,
  output logic        doneDiv,
  output logic        divByZero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, INIT, LOAD, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [23:0] p_q, p_d;
  logic [23:0] a_q, a_d;
  logic [23:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [24:0] trial;
  logic [25:0] diff;
  logic        borrow;

  // P < B holds after Load, so a successful subtraction always fits back into 24 bits.
  assign trial  = {p_q, a_q[23]};
  assign diff   = {1'b0, trial} - {2'b00, b_q};
  assign borrow = diff[25];

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (startDiv) state_d = INIT;
      end
      INIT: begin
        dbz_d = 1'b0;
        ovf_d = 1'b0;
        cnt_d = 5'd0;
        if (!startDiv) state_d = LOAD;
      end
      LOAD: begin
        p_d = N[47:24];
        a_d = N[23:0];
        b_d = D;
        if (D == 24'd0) begin
          dbz_d   = 1'b1;
          a_d     = 24'hFFFFFF;
          state_d = IDLE;
        end else if (N[47:24] >= D) begin
          ovf_d   = 1'b1;
          a_d     = 24'hFFFFFF;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!borrow) begin
          p_d = diff[23:0];
          a_d = {a_q[22:0], 1'b1};
        end else begin
          p_d = trial[23:0];
          a_d = {a_q[22:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= 24'd0;
      a_q     <= 24'd0;
      b_q     <= 24'd0;
      cnt_q   <= 5'd0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q         = a_q;
  assign R         = p_q;
  assign doneDiv   = (state_q == IDLE);
  assign divByZero = dbz_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_div24.sv
// Self-checking bench for seq_div24: directed cases plus randomized operands
// compared against a plain-arithmetic division model.
module tb_seq_div24;

  logic        clk;
  logic        rst;
  logic        startDiv;
  logic [47:0] N;
  logic [23:0] D;
  logic [23:0] Q;
  logic [23:0] R;
  logic        doneDiv;
  logic        divByZero;
  logic        overflow;

  int checks;
  int errors;

  seq_div24 dut (
    .clk       (clk),
    .rst       (rst),
    .startDiv  (startDiv),
    .N         (N),
    .D         (D),
    .Q         (Q),
    .R         (R),
    .doneDiv   (doneDiv),
    .divByZero (divByZero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; lat counts clock edges from the edge on which Init sees startDiv=0
  // until doneDiv is observed high.
  task automatic run_div(input logic [47:0] n, input logic [23:0] d, input int hold,
                         input int pulse_at, output int lat);
    @(negedge clk);
    N        = n;
    D        = d;
    startDiv = 1'b1;
    repeat (hold) @(negedge clk);
    chk("busy_in_init", {63'd0, doneDiv}, 64'd0);
    if (hold >= 2) begin
      chk("dbz_cleared_in_init", {63'd0, divByZero}, 64'd0);
      chk("ovf_cleared_in_init", {63'd0, overflow}, 64'd0);
    end
    startDiv = 1'b0;
    @(posedge clk);
    #1;
    lat = 0;
    while (doneDiv !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        N = 48'({$urandom(), $urandom()});
        D = 24'($urandom());
      end
      if (pulse_at > 0 && lat == pulse_at) startDiv = 1'b1;
      if (pulse_at > 0 && lat == pulse_at + 2) startDiv = 1'b0;
    end
  endtask

  task automatic do_op(input string tag, input logic [47:0] n, input logic [23:0] d,
                       input int hold, input int pulse_at);
    logic [23:0] eq, er;
    logic        edbz, eovf;
    int          elat, lat;
    edbz = 1'b0;
    eovf = 1'b0;
    if (d == 24'd0) begin
      edbz = 1'b1;
      eq   = 24'hFFFFFF;
      er   = n[47:24];
      elat = 1;
    end else if (n[47:24] >= d) begin
      eovf = 1'b1;
      eq   = 24'hFFFFFF;
      er   = n[47:24];
      elat = 1;
    end else begin
      eq   = 24'(n / {24'd0, d});
      er   = 24'(n % {24'd0, d});
      elat = 25;
    end
    run_div(n, d, hold, pulse_at, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_Q"}, {40'd0, Q}, {40'd0, eq});
    chk({tag, "_R"}, {40'd0, R}, {40'd0, er});
    chk({tag, "_divByZero"}, {63'd0, divByZero}, {63'd0, edbz});
    chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, eovf});
    $display("op %s N=%012h D=%06h -> Q=%06h R=%06h dbz=%0d ovf=%0d lat=%0d",
             tag, n, d, Q, R, divByZero, overflow, lat);
  endtask

  initial begin
    logic [23:0] ra, rb, rr;
    logic [47:0] rn;
    logic [23:0] rd;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    startDiv = 1'b0;
    N        = 48'd0;
    D        = 24'd0;
    repeat (3) @(negedge clk);
    chk("reset_Q", {40'd0, Q}, 64'd0);
    chk("reset_R", {40'd0, R}, 64'd0);
    chk("reset_done", {63'd0, doneDiv}, 64'd1);
    chk("reset_dbz", {63'd0, divByZero}, 64'd0);
    chk("reset_ovf", {63'd0, overflow}, 64'd0);
    rst = 1'b1;

    do_op("basic_100_7", 48'd100, 24'd7, 1, 0);
    do_op("shift_pattern", 48'h000005_000003, 24'h000010, 1, 0);
    do_op("mult_inverse_max", 48'hFFFFFE_000001, 24'hFFFFFF, 1, 0);
    do_op("div_by_zero", 48'h123456_789ABC, 24'd0, 1, 0);
    do_op("init_hold5_after_dbz", 48'd100, 24'd7, 5, 0);
    do_op("overflow_equal", 48'h000010_000000, 24'h10, 1, 0);
    do_op("flags_clear", 48'h000001_000000, 24'h000003, 3, 0);
    do_op("start_pulse_in_shift", 48'hABCDEF_123456, 24'hF00001, 1, 6);
    do_op("dividend_zero", 48'd0, 24'h000001, 1, 0);
    do_op("divisor_one", 48'h000000_FFFFFF, 24'h000001, 1, 0);

    // Reset asserted during the 10th Shift cycle must abort immediately.
    @(negedge clk);
    N        = 48'd100;
    D        = 24'd7;
    startDiv = 1'b1;
    @(negedge clk);
    startDiv = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_busy", {63'd0, doneDiv}, 64'd0);
    rst = 1'b0;
    #1;
    chk("midop_reset_Q", {40'd0, Q}, 64'd0);
    chk("midop_reset_R", {40'd0, R}, 64'd0);
    chk("midop_reset_done", {63'd0, doneDiv}, 64'd1);
    chk("midop_reset_dbz", {63'd0, divByZero}, 64'd0);
    chk("midop_reset_ovf", {63'd0, overflow}, 64'd0);
    $display("op midop_reset Q=%06h R=%06h done=%0d", Q, R, doneDiv);
    @(negedge clk);
    rst = 1'b1;
    do_op("after_reset_100_7", 48'd100, 24'd7, 1, 0);

    // Product plus remainder must divide back to the original factor and remainder.
    for (int i = 0; i < 20; i++) begin
      ra = 24'($urandom());
      rb = 24'($urandom_range(32'hFFFFFF, 1));
      rr = 24'($urandom_range(32'(rb) - 1, 0));
      rn = {24'd0, ra} * {24'd0, rb} + {24'd0, rr};
      do_op("mult_inverse_rand", rn, rb, 1, 0);
      chk("mult_inverse_Q_is_factor", {40'd0, Q}, {40'd0, ra});
      chk("mult_inverse_R_is_rem", {40'd0, R}, {40'd0, rr});
    end

    for (int i = 0; i < 20; i++) begin
      rd = ($urandom_range(3) == 0) ? 24'($urandom_range(15)) : 24'($urandom());
      rn = 48'({$urandom(), $urandom()});
      if ($urandom_range(1) == 1) rn[47:24] = 24'($urandom_range(32'(rd)));
      do_op("random_any", rn, rd, 1 + int'($urandom_range(2)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
